// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus initiator: FSM states, register
// addresses and control-word helpers.
package ppi_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } ppi_state_e;

    localparam logic [ADDR_W-1:0] PPI_PORT_A = 2'd0;
    localparam logic [ADDR_W-1:0] PPI_PORT_B = 2'd1;
    localparam logic [ADDR_W-1:0] PPI_PORT_C = 2'd2;
    localparam logic [ADDR_W-1:0] PPI_CTRL   = 2'd3;

    localparam logic [DATA_W-1:0] MODE_SET_FLAG = 8'h80;

    // Bit set/reset control words for port C bit bit_sel.
    function automatic logic [DATA_W-1:0] BSR_SET(input logic [2:0] bit_sel);
        return {4'b0000, bit_sel, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] BSR_CLR(input logic [2:0] bit_sel);
        return {4'b0000, bit_sel, 1'b0};
    endfunction

endpackage

// File: rtl/ppi_cycle_counter.sv
// Loadable down-counter that times each bus phase; zero marks the last cycle.
module ppi_cycle_counter
    import ppi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// CPU-side bus initiator: turns single-word commands into timed CS_n/RD_n/WR_n/A
// cycles on the PPI, driving DataBus only during the active part of a write.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 2,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic              CmdWrite,
    input  logic [ADDR_W-1:0] CmdAddr,
    input  logic [DATA_W-1:0] CmdData,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              CS_n,
    output logic              RD_n,
    output logic              WR_n,
    output logic [ADDR_W-1:0] A,
    inout  wire  [DATA_W-1:0] DataBus
);

    localparam logic [CNT_W-1:0] SETUP_LOAD    = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD   = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

    ppi_state_e        state;
    logic              write_q;
    logic [DATA_W-1:0] data_q;
    logic              drive_en;
    logic              handshake;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_zero;

    assign handshake = CmdValid && CmdReady;

    ppi_cycle_counter u_counter (
        .clk       (Clock),
        .rst       (Reset),
        .load      (cnt_load),
        .load_value(cnt_value),
        .zero      (cnt_zero)
    );

    // Reload the counter with the next phase length on every phase entry.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        unique case (state)
            ST_IDLE: begin
                cnt_load  = handshake;
                cnt_value = SETUP_LOAD;
            end
            ST_SETUP: begin
                cnt_load  = cnt_zero;
                cnt_value = STROBE_LOAD;
            end
            ST_STROBE: begin
                cnt_load  = cnt_zero;
                cnt_value = HOLD_LOAD;
            end
            ST_HOLD: begin
                cnt_load  = cnt_zero;
                cnt_value = RECOVERY_LOAD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            CmdReady <= 1'b1;
            RspValid <= 1'b0;
            RspData  <= '0;
            CS_n     <= 1'b1;
            RD_n     <= 1'b1;
            WR_n     <= 1'b1;
            A        <= '0;
            write_q  <= 1'b0;
            data_q   <= '0;
            drive_en <= 1'b0;
        end else begin
            RspValid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        write_q  <= CmdWrite;
                        A        <= CmdAddr;
                        data_q   <= CmdData;
                        drive_en <= CmdWrite;
                        CS_n     <= 1'b0;
                        CmdReady <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        RD_n  <= write_q;
                        WR_n  <= !write_q;
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // Read data is sampled on the edge that raises the strobe.
                    if (cnt_zero) begin
                        RD_n  <= 1'b1;
                        WR_n  <= 1'b1;
                        if (!write_q) begin
                            RspData <= DataBus;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        CS_n     <= 1'b1;
                        drive_en <= 1'b0;
                        RspValid <= 1'b1;
                        state    <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_zero) begin
                        CmdReady <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign DataBus = drive_en ? data_q : 'z;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: two instances (default and stretched timing) checked
// every cycle against a cycle-offset model of the bus protocol.
module tb_ppi_bus_master;
    import ppi_pkg::*;

    localparam int IDLE_K = 1000;
    localparam int S0 = 1, T0 = 2, H0 = 1, R0 = 2;
    localparam int S1 = 3, T1 = 1, H1 = 2, R1 = 1;

    logic Clock = 1'b0;
    logic Reset;

    logic       cmd_valid [2];
    logic       cmd_write [2];
    logic [1:0] cmd_addr  [2];
    logic [7:0] cmd_data  [2];

    logic       cmd_ready0, rsp_valid0, cs_n0, rd_n0, wr_n0;
    logic [7:0] rsp_data0;
    logic [1:0] a0;
    wire  [7:0] bus0;
    logic       cmd_ready1, rsp_valid1, cs_n1, rd_n1, wr_n1;
    logic [7:0] rsp_data1;
    logic [1:0] a1;
    wire  [7:0] bus1;

    // Reference model: cycles since the accepting edge plus the latched command.
    int         ps [2] = '{S0, S1};
    int         pt [2] = '{T0, T1};
    int         ph [2] = '{H0, H1};
    int         pr [2] = '{R0, R1};
    int         kk [2] = '{IDLE_K, IDLE_K};
    logic       wr_l    [2] = '{1'b0, 1'b0};
    logic [1:0] ad_l    [2] = '{2'd0, 2'd0};
    logic [7:0] dat_l   [2] = '{8'h00, 8'h00};
    logic [7:0] rd_val  [2] = '{8'h00, 8'h00};
    logic [7:0] rd_cur  [2] = '{8'h00, 8'h00};
    logic [7:0] rsp_exp [2] = '{8'h00, 8'h00};
    logic       wphase  [2] = '{1'b0, 1'b0};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    ppi_bus_master #(
        .SETUP_CYCLES(S0), .STROBE_CYCLES(T0), .HOLD_CYCLES(H0), .RECOVERY_CYCLES(R0)
    ) dut0 (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(cmd_valid[0]), .CmdReady(cmd_ready0), .CmdWrite(cmd_write[0]),
        .CmdAddr(cmd_addr[0]), .CmdData(cmd_data[0]),
        .RspValid(rsp_valid0), .RspData(rsp_data0),
        .CS_n(cs_n0), .RD_n(rd_n0), .WR_n(wr_n0), .A(a0), .DataBus(bus0)
    );

    ppi_bus_master #(
        .SETUP_CYCLES(S1), .STROBE_CYCLES(T1), .HOLD_CYCLES(H1), .RECOVERY_CYCLES(R1)
    ) dut1 (
        .Clock(Clock), .Reset(Reset),
        .CmdValid(cmd_valid[1]), .CmdReady(cmd_ready1), .CmdWrite(cmd_write[1]),
        .CmdAddr(cmd_addr[1]), .CmdData(cmd_data[1]),
        .RspValid(rsp_valid1), .RspData(rsp_data1),
        .CS_n(cs_n1), .RD_n(rd_n1), .WR_n(wr_n1), .A(a1), .DataBus(bus1)
    );

    // PPI side: read data while RD_n is low, a quiet 00 whenever the master must not drive.
    assign bus0 = wphase[0] ? 8'bz : (rd_n0 ? 8'h00 : rd_cur[0]);
    assign bus1 = wphase[1] ? 8'bz : (rd_n1 ? 8'h00 : rd_cur[1]);

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_step();
        int s, t, h, r;
        for (int l = 0; l < 2; l++) begin
            s = ps[l]; t = pt[l]; h = ph[l]; r = pr[l];
            if (Reset) begin
                kk[l] = IDLE_K; wr_l[l] = 1'b0; ad_l[l] = 2'd0; dat_l[l] = 8'h00;
                rd_cur[l] = 8'h00; rsp_exp[l] = 8'h00;
            end else begin
                if (kk[l] >= s + t + h + r && cmd_valid[l]) begin
                    kk[l] = 0; wr_l[l] = cmd_write[l]; ad_l[l] = cmd_addr[l];
                    dat_l[l] = cmd_data[l]; rd_cur[l] = rd_val[l];
                end else if (kk[l] < IDLE_K) begin
                    kk[l]++;
                end
                if (!wr_l[l] && kk[l] == s + t) rsp_exp[l] = rd_cur[l];
            end
            wphase[l] = wr_l[l] && (kk[l] < s + t + h);
        end
    endtask

    task automatic check_lane(input int l, input logic cs, input logic rd, input logic wr,
                              input logic rv, input logic rdy, input logic [1:0] a,
                              input logic [7:0] bus, input logic [7:0] rdat);
        int k, s, t, h, r;
        logic act, stb;
        logic [7:0] bexp;
        string p;
        k = kk[l]; s = ps[l]; t = pt[l]; h = ph[l]; r = pr[l];
        act = (k < s + t + h);
        stb = (k >= s) && (k < s + t);
        p = $sformatf("L%0d_", l);
        bexp = (act && wr_l[l]) ? dat_l[l] : ((stb && !wr_l[l]) ? rd_cur[l] : 8'h00);
        check({p, "cs_n"},      8'(cs),  8'(!act));
        check({p, "rd_n"},      8'(rd),  8'(!(stb && !wr_l[l])));
        check({p, "wr_n"},      8'(wr),  8'(!(stb && wr_l[l])));
        check({p, "rsp_valid"}, 8'(rv),  8'(k == s + t + h));
        check({p, "cmd_ready"}, 8'(rdy), 8'(k >= s + t + h + r));
        check({p, "addr"},      8'(a),   8'(ad_l[l]));
        check({p, "rsp_data"},  rdat,    rsp_exp[l]);
        check({p, "bus"},       bus,     bexp);
        check({p, "strobe_excl"}, 8'(rd | wr), 8'd1);
    endtask

    initial forever begin
        @(posedge Clock or posedge Reset);
        model_step();
    end

    initial forever begin
        @(negedge Clock);
        check_lane(0, cs_n0, rd_n0, wr_n0, rsp_valid0, cmd_ready0, a0, bus0, rsp_data0);
        check_lane(1, cs_n1, rd_n1, wr_n1, rsp_valid1, cmd_ready1, a1, bus1, rsp_data1);
    end

    task automatic send(input int l, input logic w, input logic [1:0] ad, input logic [7:0] d);
        bit done;
        done = 1'b0;
        cmd_write[l] = w; cmd_addr[l] = ad; cmd_data[l] = d; cmd_valid[l] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge Clock); #1;
            done = (kk[l] == 0);
        end
        cmd_valid[l] = 1'b0;
    endtask

    // Observe one access from just after its accepting edge; offsets are in edges.
    task automatic measure(input int l, output int first_lo, output int lo_len,
                           output int cs_len, output int rsp_at, output int rdy_at);
        logic lo, cs, rv, rdy;
        first_lo = -1; lo_len = 0; rsp_at = -1; rdy_at = -1;
        cs_len = ((l == 0) ? cs_n0 : cs_n1) ? 0 : 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clock); #1;
            lo  = (l == 0) ? (!rd_n0 || !wr_n0) : (!rd_n1 || !wr_n1);
            cs  = (l == 0) ? cs_n0 : cs_n1;
            rv  = (l == 0) ? rsp_valid0 : rsp_valid1;
            rdy = (l == 0) ? cmd_ready0 : cmd_ready1;
            if (lo) begin
                lo_len++;
                if (first_lo < 0) first_lo = i;
            end
            if (!cs) cs_len++;
            if (rv && rsp_at < 0) rsp_at = i;
            if (rdy && rdy_at < 0) rdy_at = i;
        end
    endtask

    initial begin
        int fl, ll, cl, ra, ya, n;
        for (int l = 0; l < 2; l++) begin
            cmd_valid[l] = 1'b0; cmd_write[l] = 1'b0; cmd_addr[l] = 2'd0; cmd_data[l] = 8'h00;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        check("rst_cs_n", 8'(cs_n0), 8'd1);
        check("rst_ready", 8'(cmd_ready0), 8'd1);
        check("rst_rsp_data", rsp_data0, 8'h00);
        check("rst_addr", 8'(a0), 8'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        // Mode-set write with default timing.
        send(0, 1'b1, PPI_CTRL, MODE_SET_FLAG);
        measure(0, fl, ll, cl, ra, ya);
        check("wr_strobe_start", 8'(fl), 8'd1);
        check("wr_strobe_len", 8'(ll), 8'd2);
        check("wr_cs_len", 8'(cl), 8'd4);
        check("wr_rsp_at", 8'(ra), 8'd4);
        check("wr_ready_at", 8'(ya), 8'd6);

        // Read of port A with the PPI returning 5A.
        rd_val[0] = 8'h5A;
        send(0, 1'b0, PPI_PORT_A, 8'hFF);
        measure(0, fl, ll, cl, ra, ya);
        check("rd_rsp_at", 8'(ra), 8'd4);
        check("rd_rsp_data", rsp_data0, 8'h5A);

        // Back-to-back BSR writes with CmdValid held high throughout.
        cmd_write[0] = 1'b1; cmd_addr[0] = PPI_CTRL; cmd_data[0] = BSR_SET(3'd3);
        cmd_valid[0] = 1'b1;
        n = 0;
        while (kk[0] != 0 && n < 20) begin @(posedge Clock); #1; n++; end
        cmd_data[0] = BSR_CLR(3'd3);
        n = 0;
        while (n < 20) begin
            @(posedge Clock); #1; n++;
            if (cmd_ready0) break;
        end
        check("bsr_ready_gap", 8'(n), 8'd6);
        @(posedge Clock); #1;
        cmd_valid[0] = 1'b0;
        check("bsr_second_cs", 8'(cs_n0), 8'd0);
        repeat (8) @(posedge Clock);
        #1;

        // Stretched setup/hold, single-cycle strobe read.
        rd_val[1] = 8'hC3;
        send(1, 1'b0, PPI_PORT_B, 8'h00);
        measure(1, fl, ll, cl, ra, ya);
        check("p_strobe_start", 8'(fl), 8'd3);
        check("p_strobe_len", 8'(ll), 8'd1);
        check("p_cs_len", 8'(cl), 8'd6);
        check("p_period", 8'(ya + 1), 8'd8);
        check("p_rsp_data", rsp_data1, 8'hC3);

        // Reset while WR_n is low aborts the access at once.
        send(0, 1'b1, PPI_PORT_C, 8'hA5);
        n = 0;
        while (wr_n0 && n < 10) begin @(posedge Clock); #1; n++; end
        check("abort_wr_low", 8'(wr_n0), 8'd0);
        #2 Reset = 1'b1;
        #1;
        check("abort_wr_n", 8'(wr_n0), 8'd1);
        check("abort_rd_n", 8'(rd_n0), 8'd1);
        check("abort_cs_n", 8'(cs_n0), 8'd1);
        check("abort_bus", bus0, 8'h00);
        @(posedge Clock); #3;
        Reset = 1'b0;
        @(posedge Clock); #1;
        send(0, 1'b1, PPI_PORT_A, 8'h3C);
        measure(0, fl, ll, cl, ra, ya);
        check("post_abort_rsp_at", 8'(ra), 8'd4);

        // Random traffic on both instances.
        repeat (1000) begin
            @(posedge Clock); #1;
            for (int l = 0; l < 2; l++) begin
                if (!cmd_valid[l] || kk[l] == 0) begin
                    cmd_valid[l] = 1'($urandom_range(0, 1));
                    cmd_write[l] = 1'($urandom_range(0, 1));
                    cmd_addr[l]  = 2'($urandom_range(0, 3));
                    cmd_data[l]  = 8'($urandom);
                    rd_val[l]    = 8'($urandom);
                end
            end
        end
        cmd_valid[0] = 1'b0;
        cmd_valid[1] = 1'b0;
        repeat (20) @(posedge Clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
